// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: HI/LO registers with modelled mult/div latency.
// Optional accumulate ops (madd/maddu/msub/msubu) are enabled by `define MDU_MADD_EN.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_hi,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rdata
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [3:0] OP_MTHI = 4'd5;
   localparam logic [3:0] OP_MTLO = 4'd6;

   logic [31:0]   r_hi, r_lo;
   logic [31:0]   r_phi, r_plo;
   logic          r_pwr;
   logic          r_busy;
   logic [CW-1:0] r_cnt;

   logic          w_go, w_div, w_sgn, w_acc, w_neg;
   logic [63:0]   w_sprod, w_uprod, w_prod, w_mres;
   logic [31:0]   w_bsafe, w_dq, w_dr;

   always_comb begin
      w_go  = 1'b0;
      w_div = 1'b0;
      w_sgn = 1'b0;
      w_acc = 1'b0;
      w_neg = 1'b0;
      case (op)
         4'd1: begin w_go = 1'b1; w_sgn = 1'b1; end
         4'd2: begin w_go = 1'b1; end
         4'd3: begin w_go = 1'b1; w_div = 1'b1; w_sgn = 1'b1; end
         4'd4: begin w_go = 1'b1; w_div = 1'b1; end
`ifdef MDU_MADD_EN
         4'd7:  begin w_go = 1'b1; w_acc = 1'b1; w_sgn = 1'b1; end
         4'd8:  begin w_go = 1'b1; w_acc = 1'b1; end
         4'd9:  begin w_go = 1'b1; w_acc = 1'b1; w_neg = 1'b1; w_sgn = 1'b1; end
         4'd10: begin w_go = 1'b1; w_acc = 1'b1; w_neg = 1'b1; end
`endif
         default: ;
      endcase
   end

   assign w_sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign w_uprod = {32'd0, a} * {32'd0, b};
   assign w_prod  = w_sgn ? w_sprod : w_uprod;

   always_comb begin
      w_mres = w_prod;
      if (w_acc) begin
         if (w_neg) w_mres = {r_hi, r_lo} - w_prod;
         else       w_mres = {r_hi, r_lo} + w_prod;
      end
   end

   // Divisor forced nonzero; a zero divisor suppresses write-back instead.
   assign w_bsafe = (b == 32'd0) ? 32'd1 : b;

   always_comb begin
      w_dq = a / w_bsafe;
      w_dr = a % w_bsafe;
      if (w_sgn) begin
         if (b == 32'hFFFF_FFFF) begin
            w_dq = 32'd0 - a;
            w_dr = 32'd0;
         end else begin
            w_dq = $signed(a) / $signed(w_bsafe);
            w_dr = $signed(a) % $signed(w_bsafe);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
         r_phi  <= 32'd0;
         r_plo  <= 32'd0;
         r_pwr  <= 1'b0;
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (r_busy) begin
         if (r_cnt == CW'(1)) begin
            if (r_pwr) begin
               r_hi <= r_phi;
               r_lo <= r_plo;
            end
            r_busy <= 1'b0;
            r_pwr  <= 1'b0;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt - CW'(1);
         end
      end else if (start && w_go) begin
         if (w_div) begin
            r_phi <= w_dr;
            r_plo <= w_dq;
            r_pwr <= (b != 32'd0);
            r_cnt <= CW'(DIV_CYCLES);
         end else begin
            r_phi <= w_mres[63:32];
            r_plo <= w_mres[31:0];
            r_pwr <= 1'b1;
            r_cnt <= CW'(MULT_CYCLES);
         end
         r_busy <= 1'b1;
      end else if (!start) begin
         if (op == OP_MTHI) r_hi <= a;
         if (op == OP_MTLO) r_lo <= a;
      end
   end

   assign busy  = r_busy;
   assign hi    = r_hi;
   assign lo    = r_lo;
   assign rdata = rd_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: table-driven op vectors plus hand-written
// sequences for mthi/mtlo, busy interlock, reset abort and accumulate ops.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        rd_hi;
   logic        busy;
   logic [31:0] hi, lo, rdata;

   int n_chk  = 0;
   int n_fail = 0;

   e_mdu dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .rd_hi (rd_hi),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo),
      .rdata (rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
      int          ecyc;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge, then count busy cycles (bounded).
   task automatic run_start(input logic [3:0] o, input logic [31:0] x,
                            input logic [31:0] y, output int cyc);
      start = 1'b1; op = o; a = x; b = y;
      tick();
      start = 1'b0; op = 4'd0;
      cyc = 0;
      while (busy && cyc < 60) begin
         cyc++;
         tick();
      end
   endtask

   initial begin
      int cyc;
      vt[0] = '{"mult_neg",  4'd1,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
      vt[1] = '{"multu_big", 4'd2,  32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
      vt[2] = '{"div_neg",   4'd3,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vt[3] = '{"divu_zero", 4'd4,  32'd7,         32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vt[4] = '{"div_ovf",   4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
      vt[5] = '{"divu_100",  4'd4,  32'd100,       32'd7,        32'd2,         32'd14,        10};
      vt[6] = '{"div_negb",  4'd3,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
      vt[7] = '{"mult_2e32", 4'd1,  32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         5};
      vt[8] = '{"nop_start", 4'd0,  32'd9,         32'd9,        32'd1,         32'd0,         0};
      vt[9] = '{"rsvd_op",   4'd11, 32'd9,         32'd9,        32'd1,         32'd0,         0};

      reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; rd_hi = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);

      for (int i = 0; i < 10; i++) begin
         run_start(vt[i].op, vt[i].a, vt[i].b, cyc);
         chk({vt[i].name, "_cyc"}, cyc, vt[i].ecyc);
         chk({vt[i].name, "_hi"}, hi, vt[i].ehi);
         chk({vt[i].name, "_lo"}, lo, vt[i].elo);
      end

      // rdata mux
      rd_hi = 1'b1; #1;
      chk("rdata_hi", rdata, 32'd1);
      rd_hi = 1'b0; #1;
      chk("rdata_lo", rdata, 32'd0);

      // mthi with start=0, idle
      op = 4'd5; a = 32'h1234_5678;
      tick();
      op = 4'd0;
      chk("mthi_hi", hi, 32'h1234_5678);
      chk("mthi_busy", {31'd0, busy}, 32'd0);

      // mtlo and a second start while busy are both ignored
      start = 1'b1; op = 4'd1; a = 32'd2; b = 32'd3;
      tick();
      start = 1'b0; op = 4'd0;
      cyc = 1;
      tick(); cyc++;
      op = 4'd6; a = 32'hDEAD_BEEF;
      tick(); cyc++;
      op = 4'd0;
      chk("mtlo_busy_lo", lo, 32'd0);
      start = 1'b1; op = 4'd2; a = 32'd100; b = 32'd100;
      tick(); cyc++;
      start = 1'b0; op = 4'd0;
      chk("start_busy_hi", hi, 32'h1234_5678);
      while (busy && cyc < 60) begin
         cyc++;
         tick();
      end
      chk("busy_ign_cyc", cyc - 1, 32'd5);
      chk("busy_ign_hi", hi, 32'd0);
      chk("busy_ign_lo", lo, 32'd6);

      // reset during the 3rd busy cycle aborts write-back
      start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd5;
      tick();
      start = 1'b0; op = 4'd0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_lo", lo, 32'd0);
      repeat (8) tick();
      chk("rstmid_late_lo", lo, 32'd0);
      chk("rstmid_late_hi", hi, 32'd0);

      // accumulate ops: HI=0, LO=FFFFFFFF then maddu 1*1
      op = 4'd6; a = 32'hFFFF_FFFF;
      tick();
      op = 4'd0;
      run_start(4'd8, 32'd1, 32'd1, cyc);
`ifdef MDU_MADD_EN
      chk("maddu_cyc", cyc, 32'd5);
      chk("maddu_hi", hi, 32'd1);
      chk("maddu_lo", lo, 32'd0);
      run_start(4'd9, 32'd1, 32'd1, cyc);
      chk("msub_cyc", cyc, 32'd5);
      chk("msub_hi", hi, 32'd0);
      chk("msub_lo", lo, 32'hFFFF_FFFF);
`else
      chk("maddu_cyc", cyc, 32'd0);
      chk("maddu_hi", hi, 32'd0);
      chk("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
